// File: rtl/bus_pkg.sv
// Shared definitions for the external-bus initiator: FSM encoding, default
// phase timings and the address region that no slave ever answers.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_STROBE_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES   = 1;
  localparam int DEF_TIMEOUT       = 16;

  // One timer serves every phase, so it must hold the largest phase length.
  localparam int TMR_W = 8;

  localparam logic [15:0] UNMAPPED_LO = 16'hF000;
  localparam logic [15:0] UNMAPPED_HI = 16'hFF00;

  function automatic logic in_unmapped(input logic [15:0] ad);
    return (ad >= UNMAPPED_LO) && (ad < UNMAPPED_HI);
  endfunction

endpackage

// File: rtl/bus_master_if.sv
// Core request/response and board-bus signals of the initiator, grouped so the
// master and its surroundings see the same bundle from opposite sides.
interface bus_master_if;

  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ack;
  logic        err;
  logic [7:0]  rdata;
  logic [15:0] a;
  logic        n_oe;
  logic        n_we;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  d_in;
  logic        n_rdy;

  modport master (
    input  req, we, addr, wdata, d_in, n_rdy,
    output ack, err, rdata, a, n_oe, n_we, d_out, d_oe
  );

  modport slave (
    output req, we, addr, wdata, d_in, n_rdy,
    input  ack, err, rdata, a, n_oe, n_we, d_out, d_oe
  );

endinterface

// File: rtl/bus_timer.sv
// Loadable down-counter that saturates at zero; tc is high while the count is zero.
// A load takes priority over a decrement in the same cycle.
module bus_timer
  import bus_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/bus_master.sv
// Single-beat bus initiator: IDLE->SETUP->STROBE->HOLD->DONE, 6 cycles per access with
// default timing; n_rdy stretches the strobe one cycle per wait state up to TIMEOUT extra cycles.
module bus_master
  import bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  bus_master_if.master  bus
);

  localparam logic [TMR_W-1:0] SETUP_LD   = TMR_W'(SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] STROBE_LD  = TMR_W'(STROBE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LD    = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic        n_oe_q, n_oe_d;
  logic        n_we_q, n_we_d;
  logic [7:0]  d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        err_flag_q, err_flag_d;
  logic        waiting_q, waiting_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_tc;
  logic             strobe_end;

  bus_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    n_oe_d     = n_oe_q;
    n_we_d     = n_we_q;
    d_out_d    = d_out_q;
    d_oe_d     = d_oe_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    we_d       = we_q;
    err_flag_d = err_flag_q;
    waiting_d  = waiting_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_en     = 1'b0;
    strobe_end = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          state_d  = ST_SETUP;
          a_d      = bus.addr;
          we_d     = bus.we;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
          if (bus.we) begin
            d_out_d = bus.wdata;
            d_oe_d  = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        if (tmr_tc) begin
          state_d   = ST_STROBE;
          n_oe_d    = we_q;
          n_we_d    = !we_q;
          waiting_d = 1'b0;
          tmr_load  = 1'b1;
          tmr_val   = STROBE_LD;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_STROBE: begin
        // After the minimum strobe the timer is reloaded once and then
        // counts the wait states; running out of them is the timeout.
        if (tmr_tc || waiting_q) begin
          if (!bus.n_rdy) begin
            if (!we_q) begin
              rdata_d = bus.d_in;
            end
            strobe_end = 1'b1;
          end else if (!waiting_q) begin
            waiting_d = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = TIMEOUT_LD;
          end else if (tmr_tc) begin
            err_flag_d = 1'b1;
            strobe_end = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end else begin
          tmr_en = 1'b1;
        end

        if (strobe_end) begin
          state_d  = ST_HOLD;
          n_oe_d   = 1'b1;
          n_we_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end

      ST_HOLD: begin
        if (tmr_tc) begin
          state_d = ST_DONE;
          d_oe_d  = 1'b0;
          ack_d   = 1'b1;
          err_d   = err_flag_q;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_DONE: begin
        state_d    = ST_IDLE;
        err_flag_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      a_q        <= 16'h0000;
      n_oe_q     <= 1'b1;
      n_we_q     <= 1'b1;
      d_out_q    <= 8'h00;
      d_oe_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 8'h00;
      we_q       <= 1'b0;
      err_flag_q <= 1'b0;
      waiting_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      n_oe_q     <= n_oe_d;
      n_we_q     <= n_we_d;
      d_out_q    <= d_out_d;
      d_oe_q     <= d_oe_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      we_q       <= we_d;
      err_flag_q <= err_flag_d;
      waiting_q  <= waiting_d;
    end
  end

  assign bus.a     = a_q;
  assign bus.n_oe  = n_oe_q;
  assign bus.n_we  = n_we_q;
  assign bus.d_out = d_out_q;
  assign bus.d_oe  = d_oe_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_bus_master.sv
// Directed and randomized accesses against a cycle-count model of the bus protocol.
module tb_bus_master;

  localparam int SETUP   = 1;
  localparam int STROBE  = 2;
  localparam int HOLD    = 1;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;
  int n_tests;
  int n_fail;
  int unsigned gcyc;
  int unsigned last_ack_g;
  logic [7:0] ref_rdata;

  bus_master_if bus();

  bus_master #(
    .SETUP_CYCLES  (SETUP),
    .STROBE_CYCLES (STROBE),
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT       (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial gcyc = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge in IDLE (cycle 0); returns at the negedge of the IDLE
  // cycle following DONE. The slave holds n_rdy high for nwait wait cycles.
  task automatic run_access(input logic w, input logic [15:0] ad, input logic [7:0] wd,
                            input logic [7:0] din, input int nwait, input bit hold_req,
                            input string tag);
    int  ack_c, lo_first, lo_last, wrong, a_bad, doe_bad, dout_bad, inv_bad;
    int  exp_w, exp_ack, rdy_cyc;
    bit  exp_err, stb_low;
    logic err_o;
    logic [7:0] rdata_o;

    exp_err = (nwait > TIMEOUT);
    exp_w   = exp_err ? TIMEOUT : nwait;
    exp_ack = SETUP + STROBE + exp_w + HOLD + 1;
    rdy_cyc = SETUP + STROBE + nwait;
    ack_c = 0; lo_first = 0; lo_last = 0; wrong = 0; a_bad = 0;
    doe_bad = 0; dout_bad = 0; inv_bad = 0; err_o = 1'b0; rdata_o = 8'h00;

    bus.req = 1'b1; bus.we = w; bus.addr = ad; bus.wdata = wd;
    bus.d_in = ~din; bus.n_rdy = 1'b1;

    for (int c = 1; (c <= exp_ack + 8) && (ack_c == 0); c++) begin
      @(posedge clk);
      @(negedge clk);
      if (!hold_req) bus.req = 1'b0;
      bus.addr  = 16'($urandom);
      bus.wdata = 8'($urandom);
      bus.we    = 1'($urandom);
      bus.n_rdy = (c < rdy_cyc) ? 1'b1 : 1'b0;
      bus.d_in  = (c == rdy_cyc) ? din : ~din;

      stb_low = w ? !bus.n_we : !bus.n_oe;
      if (stb_low) begin
        if (lo_first == 0) lo_first = c;
        lo_last = c;
      end
      if (w ? !bus.n_oe : !bus.n_we) wrong++;
      if (!bus.n_oe && !bus.n_we) inv_bad++;
      if (bus.d_oe && !bus.n_oe) inv_bad++;
      if (bus.a !== ad) a_bad++;
      if (bus.d_oe !== (w && (c < exp_ack))) doe_bad++;
      if (w && bus.d_oe && (bus.d_out !== wd)) dout_bad++;
      if (bus.ack === 1'b1) begin
        ack_c = c;
        err_o = bus.err;
        rdata_o = bus.rdata;
        last_ack_g = gcyc;
      end
    end

    if (!w && !exp_err) ref_rdata = din;

    chk({tag, ".ack_cycle"}, 64'(ack_c), 64'(exp_ack));
    chk({tag, ".err"}, {63'd0, err_o}, {63'd0, exp_err});
    chk({tag, ".rdata"}, {56'd0, rdata_o}, {56'd0, ref_rdata});
    chk({tag, ".strobe_first"}, 64'(lo_first), 64'(SETUP + 1));
    chk({tag, ".strobe_last"}, 64'(lo_last), 64'(SETUP + STROBE + exp_w));
    chk({tag, ".wrong_strobe"}, 64'(wrong), 64'd0);
    chk({tag, ".addr_stable"}, 64'(a_bad), 64'd0);
    chk({tag, ".d_oe"}, 64'(doe_bad), 64'd0);
    chk({tag, ".d_out"}, 64'(dout_bad), 64'd0);
    chk({tag, ".invariants"}, 64'(inv_bad), 64'd0);

    @(posedge clk);
    @(negedge clk);
    chk({tag, ".post_idle"}, {59'd0, bus.ack, bus.err, bus.n_oe, bus.n_we, bus.d_oe},
        {59'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    chk({tag, ".post_addr"}, {48'd0, bus.a}, {48'd0, ad});
  endtask

  initial begin
    int unsigned t0, t1, t2;
    int acks;
    logic w;
    logic [15:0] ad;
    int nw;

    n_tests = 0;
    n_fail = 0;
    ref_rdata = 8'h00;
    last_ack_g = 0;
    rst = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 16'h0; bus.wdata = 8'h0;
    bus.d_in = 8'h0; bus.n_rdy = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state",
        {27'd0, bus.a, bus.n_oe, bus.n_we, bus.d_oe, bus.d_out, bus.ack, bus.err, bus.rdata},
        {27'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
    rst = 1'b0;
    @(negedge clk);

    run_access(1'b0, 16'h1234, 8'h00, 8'h5A, 0, 1'b0, "rd_1234");
    run_access(1'b1, 16'hFF04, 8'hC3, 8'h00, 0, 1'b0, "wr_FF04");
    run_access(1'b0, 16'hA000, 8'h00, 8'h77, 3, 1'b0, "rd_A000_wait3");
    run_access(1'b0, 16'hF000, 8'h00, 8'hEE, 1000, 1'b0, "rd_F000_timeout");
    run_access(1'b0, 16'h2000, 8'h00, 8'h3C, TIMEOUT, 1'b0, "rd_max_wait");

    // Reset while a write strobe is low.
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h3456; bus.wdata = 8'h99; bus.n_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid.strobe_low", {63'd0, bus.n_we}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid.outputs", {45'd0, bus.n_we, bus.n_oe, bus.d_oe, bus.a},
        {45'd0, 1'b1, 1'b1, 1'b0, 16'h0000});
    acks = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) acks++;
    end
    chk("rst_mid.no_ack", 64'(acks), 64'd0);
    ref_rdata = 8'h00;
    run_access(1'b0, 16'h0042, 8'h00, 8'hA5, 1, 1'b0, "rd_after_rst");

    // req held high: one access every 6 cycles.
    run_access(1'b0, 16'h0100, 8'h00, 8'h11, 0, 1'b1, "b2b_0");
    t0 = last_ack_g;
    run_access(1'b0, 16'h0200, 8'h00, 8'h22, 0, 1'b1, "b2b_1");
    t1 = last_ack_g;
    run_access(1'b0, 16'h0300, 8'h00, 8'h33, 0, 1'b1, "b2b_2");
    t2 = last_ack_g;
    bus.req = 1'b0;
    chk("b2b.spacing01", 64'(t1 - t0), 64'd6);
    chk("b2b.spacing12", 64'(t2 - t1), 64'd6);

    for (int k = 0; k < 12; k++) begin
      w  = 1'($urandom);
      ad = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ad = 16'hF000 + 16'($urandom_range(0, 16'h0EFF));
      if ((ad >= 16'hF000) && (ad < 16'hFF00)) begin
        nw = TIMEOUT + 1 + int'($urandom_range(0, 5));
      end else if ($urandom_range(0, 2) == 0) begin
        nw = int'($urandom_range(0, TIMEOUT + 4));
      end else begin
        nw = int'($urandom_range(0, 2));
      end
      run_access(w, ad, 8'($urandom), 8'($urandom), nw, 1'b0, $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_master.md
Name: bus_master

Overview:
- CPU-side initiator for the external memory/IO bus that the address decoder serves.
- Turns single-beat read/write requests from the core into timed address, `n_oe`/`n_we` strobe and data-drive sequences.
- Inserts wait states while the decoder holds `n_rdy` high.
- Reports a bus error when a slave never becomes ready; the unmapped 0xF000–0xFEFF region always ends this way.
- Sits between the core's load/store unit and the board bus; all bus outputs are registered so strobes are glitch-free.

Parameters:
- SETUP_CYCLES, 1: cycles the address is stable before the strobe falls (>=1).
- STROBE_CYCLES, 2: minimum strobe-low cycles (>=1).
- HOLD_CYCLES, 1: cycles the address and write data are held after the strobe rises (>=1).
- TIMEOUT, 16: maximum extra strobe cycles allowed while `n_rdy`=1 before an error (>=1).

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; qualified by `req`.
- addr  in  16  access address.
- wdata  in  8  write data.
- ack  out  1  one-cycle pulse: the access is complete.
- err  out  1  valid with `ack`: 1 = the access timed out.
- rdata  out  8  read data; valid from `ack` until the next read's `ack`.
- a  out  16  bus address.
- n_oe  out  1  bus output enable, active-low.
- n_we  out  1  bus write strobe, active-low.
- d_out  out  8  bus write data.
- d_oe  out  1  1 = the master drives the data bus.
- d_in  in  8  bus read data.
- n_rdy  in  1  slave not-ready from the decoder; 1 = insert a wait state.

Behaviour:
- Reset values, applied at the first clock edge with `rst`=1: state IDLE, `a`=0x0000, `n_oe`=1, `n_we`=1, `d_oe`=0, `d_out`=0x00, `ack`=0, `err`=0, `rdata`=0x00, counters 0.
- Reset mid-access: both strobes and `d_oe` deassert at that same edge. No `ack` is issued for the aborted access.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - `req`=1 at an edge latches `addr`, `we`, `wdata`. `a` takes the address at that edge; state becomes SETUP.
  - For a write, `d_out`=`wdata` and `d_oe`=1 from the same edge.
- SETUP:
  - Strobes stay high for SETUP_CYCLES cycles.
  - Then the state becomes STROBE: `n_oe`=0 for a read, or `n_we`=0 for a write.
- STROBE:
  - A counter runs; the strobe stays low for at least STROBE_CYCLES cycles.
  - In the last minimum cycle and every later cycle, `n_rdy` is sampled.
  - `n_rdy`=0 at such an edge: for a read, `d_in` is captured into `rdata`. State becomes HOLD and the strobe rises at that edge.
  - `n_rdy`=1: stay in STROBE and increment the wait counter.
  - Wait counter reaching TIMEOUT: set the error flag, go to HOLD, release the strobe. `rdata` is left unchanged.
- HOLD:
  - Strobes high for HOLD_CYCLES cycles.
  - `a` unchanged; `d_oe`/`d_out` unchanged for writes.
  - On exit, `d_oe` goes to 0.
- DONE:
  - Exactly one cycle: `ack`=1, `err`=error flag.
  - `req` is ignored in this cycle; state becomes IDLE and the error flag clears.
- Invariants:
  - `n_oe` and `n_we` are never low simultaneously.
  - `d_oe`=1 never coincides with `n_oe`=0.
  - `a` never changes while either strobe is low.
- Latency with defaults and no wait states:
  - `req` accepted at edge 0.
  - Strobe low during cycles 2–3.
  - `ack`=1 during cycle 5.
  - Back-to-back requests give one access per 6 cycles.
- Each wait state adds exactly one cycle.
- Timeout case: `ack` arrives TIMEOUT cycles later than the no-wait case.
- `req` held high continuously is re-accepted in the IDLE cycle after DONE.

Decomposition:
- Shared package `bus_pkg`:
  - FSM state encoding.
  - Default timing constants: SETUP/STROBE/HOLD/TIMEOUT.
  - Region bounds: 0xF000, 0xFF00.
- One sub-module `bus_timer`: a loadable down-counter with terminal-count flag, reused for the setup, strobe, hold and timeout phases.

Test Plan:
- Read 0x1234, `n_rdy`=0, `d_in`=0x5A:
  - `n_oe` low in cycles 2–3, `n_we`=1 throughout, `d_oe`=0.
  - `ack`=1 in cycle 5, `err`=0, `rdata`=0x5A.
- Write 0xFF04 with 0xC3:
  - `d_oe`=1 from cycle 0 to end of HOLD, `d_out`=0xC3.
  - `n_we` low in cycles 2–3, `n_oe` high throughout.
  - `ack` in cycle 5.
- Read 0xA000 with `n_rdy` held 1 for 3 extra cycles, then 0:
  - `n_oe` low for 5 cycles.
  - `ack` in cycle 8, `err`=0.
- Read 0xF000, `n_rdy` stuck 1:
  - `ack` in cycle 5+16=21, `err`=1, `rdata` unchanged.
  - Strobes high at `ack`.
- `rst` asserted during the STROBE of a write:
  - At the next edge `n_we`=1, `d_oe`=0, `a`=0.
  - No `ack`; a following read completes normally.
- `req` held high for 3 back-to-back reads:
  - `ack` in cycles 5, 11, 17.
  - Invariants checked every cycle: `n_oe`/`n_we` never both low, `a` stable while a strobe is low.
